// File: rtl/cacheline_adaptor_if.sv
// Line-side and memory-side signal bundle for the cacheline adaptor.
// The slave modport is the adaptor's view; the master modport drives it.
interface cacheline_adaptor_if #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
);

   logic [LINE_W-1:0]  line_i;
   logic [LINE_W-1:0]  line_o;
   logic [ADDR_W-1:0]  address_i;
   logic               read_i;
   logic               write_i;
   logic               resp_o;

   logic [BURST_W-1:0] burst_i;
   logic [BURST_W-1:0] burst_o;
   logic [ADDR_W-1:0]  address_o;
   logic               read_o;
   logic               write_o;
   logic               resp_i;

   modport slave (
      input  line_i,
      input  address_i,
      input  read_i,
      input  write_i,
      input  burst_i,
      input  resp_i,
      output line_o,
      output resp_o,
      output burst_o,
      output address_o,
      output read_o,
      output write_o
   );

   modport master (
      output line_i,
      output address_i,
      output read_i,
      output write_i,
      output burst_i,
      output resp_i,
      input  line_o,
      input  resp_o,
      input  burst_o,
      input  address_o,
      input  read_o,
      input  write_o
   );

endinterface

// File: rtl/cacheline_adaptor.sv
// Converts single-line read/write requests into BEATS-beat memory bursts,
// assembling read beats into a line and slicing write lines into beats.
module cacheline_adaptor #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int BEATS   = 4,
   parameter int ADDR_W  = 32
) (
   input logic                clk,
   input logic                rst,
   cacheline_adaptor_if.slave bus
);

   localparam int CNT_W    = $clog2(BEATS);
   localparam int OFFSET_W = $clog2(LINE_W / 8);

   localparam logic [ADDR_W-1:0] ALIGN_MASK =
      ~((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RD_BURST = 3'd1;
   localparam logic [2:0] RD_DONE  = 3'd2;
   localparam logic [2:0] WR_BURST = 3'd3;
   localparam logic [2:0] WR_DONE  = 3'd4;

   logic [2:0]         state_q,   state_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic [LINE_W-1:0]  lineBuf_q, lineBuf_d;
   logic [LINE_W-1:0]  lineOut_q, lineOut_d;
   logic [ADDR_W-1:0]  addr_q,    addr_d;

   logic [ADDR_W-1:0]  alignedAddr;
   logic               lastBeat;
   logic [BURST_W-1:0] beatSel;

   assign alignedAddr = bus.address_i & ALIGN_MASK;
   assign lastBeat    = (cnt_q == CNT_W'(BEATS - 1));

   // Current write beat taken from the latched line, beat 0 in the low bits.
   always_comb begin
      beatSel = '0;
      for (int i = 0; i < BEATS; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            beatSel = lineBuf_q[i*BURST_W +: BURST_W];
         end
      end
   end

   // Next-state logic; line_o only changes when a read completes so
   // partially assembled lines never leak out.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lineBuf_d = lineBuf_q;
      lineOut_d = lineOut_q;
      addr_d    = addr_q;

      case (state_q)
         IDLE: begin
            if (bus.read_i) begin
               addr_d  = alignedAddr;
               cnt_d   = '0;
               state_d = RD_BURST;
            end else if (bus.write_i) begin
               lineBuf_d = bus.line_i;
               addr_d    = alignedAddr;
               cnt_d     = '0;
               state_d   = WR_BURST;
            end
         end

         RD_BURST: begin
            if (bus.resp_i) begin
               for (int i = 0; i < BEATS; i++) begin
                  if (cnt_q == CNT_W'(i)) begin
                     lineBuf_d[i*BURST_W +: BURST_W] = bus.burst_i;
                  end
               end
               if (lastBeat) begin
                  cnt_d     = '0;
                  lineOut_d = lineBuf_d;
                  state_d   = RD_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         RD_DONE: begin
            state_d = IDLE;
         end

         WR_BURST: begin
            if (bus.resp_i) begin
               if (lastBeat) begin
                  cnt_d   = '0;
                  state_d = WR_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         WR_DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous reset that also aborts any burst.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         lineBuf_q <= '0;
         lineOut_q <= '0;
         addr_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lineBuf_q <= lineBuf_d;
         lineOut_q <= lineOut_d;
         addr_q    <= addr_d;
      end
   end

   assign bus.read_o    = (state_q == RD_BURST);
   assign bus.write_o   = (state_q == WR_BURST);
   assign bus.resp_o    = (state_q == RD_DONE) || (state_q == WR_DONE);
   assign bus.address_o = addr_q;
   assign bus.burst_o   = (state_q == WR_BURST) ? beatSel : '0;
   assign bus.line_o    = lineOut_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: stimulus queues expected beats and
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_cacheline_adaptor;

   localparam int LINE_W  = 256;
   localparam int BURST_W = 64;
   localparam int BEATS   = 4;
   localparam int ADDR_W  = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   cacheline_adaptor_if #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) bus ();

   cacheline_adaptor #(
      .LINE_W (LINE_W),
      .BURST_W(BURST_W),
      .BEATS  (BEATS),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      bit                isRead;
      logic [LINE_W-1:0] line;
      int                cycles;
   } resp_t;

   resp_t              expResp[$];
   logic [BURST_W-1:0] expBeat[$];
   logic [ADDR_W-1:0]  expAddr = '0;
   logic [LINE_W-1:0]  lastReadLine = '0;
   int                 vectors = 0;
   int                 miscompares = 0;
   int                 burstCycles = 0;
   bit                 lastKindRead = 1'b0;

   task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                              input logic [LINE_W-1:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic reportFail(input string name);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s", name);
   endtask

   // Monitor: memory-side beats and addresses, then line-side responses.
   always @(negedge clk) begin
      if (rst) begin
         burstCycles = 0;
      end else begin
         if (bus.read_o && bus.write_o) begin
            reportFail("read_o and write_o both high");
         end
         if (bus.read_o || bus.write_o) begin
            burstCycles++;
            lastKindRead = bus.read_o;
            checkOutput("address_o", LINE_W'(bus.address_o), LINE_W'(expAddr));
            if (bus.write_o) begin
               if (expBeat.size() == 0) begin
                  reportFail("write beat with no expected beat");
               end else begin
                  checkOutput("burst_o", LINE_W'(bus.burst_o), LINE_W'(expBeat[0]));
                  if (bus.resp_i) begin
                     void'(expBeat.pop_front());
                  end
               end
            end
         end
         if (bus.resp_o) begin
            if (expResp.size() == 0) begin
               reportFail("unexpected resp_o");
            end else begin
               resp_t e;
               e = expResp.pop_front();
               checkOutput("resp kind read", LINE_W'(lastKindRead), LINE_W'(e.isRead));
               checkOutput("line_o", bus.line_o, e.line);
               checkOutput("burst cycles", LINE_W'(burstCycles), LINE_W'(e.cycles));
            end
            burstCycles = 0;
         end
      end
   end

   // One transaction: request for one cycle, then drive resp_i by pattern
   // (bit 0 first, ones after patLen) while scrambling line-side inputs.
   task automatic applyStimulus(input bit isRead, input bit both,
                                input logic [ADDR_W-1:0] addr,
                                input logic [ADDR_W-1:0] alignedExp,
                                input logic [LINE_W-1:0] wline,
                                input logic [LINE_W-1:0] rline,
                                input logic [15:0] pattern, input int patLen,
                                input bit noisy);
      int k;
      int cyc;
      bit b;
      @(posedge clk); #1;
      bus.address_i = addr;
      bus.line_i    = wline;
      bus.read_i    = isRead;
      bus.write_i   = !isRead || both;
      expAddr       = alignedExp;
      if (!isRead) begin
         for (int i = 0; i < BEATS; i++) expBeat.push_back(wline[i*BURST_W +: BURST_W]);
      end
      @(posedge clk); #1;
      bus.read_i    = 1'b0;
      bus.write_i   = 1'b0;
      bus.address_i = ~addr;
      bus.line_i    = ~wline;
      k   = 0;
      cyc = 0;
      while (k < BEATS && cyc < 64) begin
         b = (cyc < patLen) ? pattern[cyc] : 1'b1;
         bus.resp_i  = b;
         bus.burst_i = b ? rline[k*BURST_W +: BURST_W] : 64'hDEAD_BEEF_0BAD_F00D;
         if (noisy && !(b && k == BEATS - 1)) begin
            if (isRead) bus.write_i = 1'b1;
            else        bus.read_i  = 1'b1;
         end else begin
            bus.read_i  = 1'b0;
            bus.write_i = 1'b0;
         end
         @(posedge clk); #1;
         if (b) k++;
         cyc++;
      end
      bus.resp_i  = 1'b0;
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
      if (isRead) lastReadLine = rline;
      expResp.push_back('{isRead, lastReadLine, cyc});
   endtask

   initial begin
      bus.line_i    = '0;
      bus.address_i = '0;
      bus.read_i    = 1'b0;
      bus.write_i   = 1'b0;
      bus.burst_i   = '0;
      bus.resp_i    = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset read_o",    LINE_W'(bus.read_o),    '0);
      checkOutput("reset write_o",   LINE_W'(bus.write_o),   '0);
      checkOutput("reset resp_o",    LINE_W'(bus.resp_o),    '0);
      checkOutput("reset line_o",    bus.line_o,             '0);
      checkOutput("reset burst_o",   LINE_W'(bus.burst_o),   '0);
      checkOutput("reset address_o", LINE_W'(bus.address_o), '0);
      @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] zero-wait read");
      applyStimulus(1'b1, 1'b0, 32'h0000_1234, 32'h0000_1220, '0,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    16'h0000, 0, 1'b0);

      $display("[TB] write with gaps and noisy inputs");
      applyStimulus(1'b0, 1'b0, 32'h0000_ABCD, 32'h0000_ABC0,
                    {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                     64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                    '0, 16'b0000_0000_0110_0101, 7, 1'b1);

      $display("[TB] simultaneous read and write, top address");
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0,
                    {4{64'h5A5A_5A5A_5A5A_5A5A}},
                    {64'hF0F0_0000_0000_0003, 64'hE0E0_0000_0000_0002,
                     64'hD0D0_0000_0000_0001, 64'hC0C0_0000_0000_0000},
                    16'b0000_0000_0000_1011, 4, 1'b1);

      $display("[TB] reset after two read beats");
      @(posedge clk); #1;
      bus.read_i    = 1'b1;
      bus.address_i = 32'h0000_0047;
      expAddr       = 32'h0000_0040;
      @(posedge clk); #1;
      bus.read_i  = 1'b0;
      bus.resp_i  = 1'b1;
      bus.burst_i = 64'h5555_5555_5555_5555;
      @(posedge clk); #1;
      bus.burst_i = 64'h6666_6666_6666_6666;
      @(posedge clk); #1;
      bus.resp_i = 1'b0;
      rst        = 1'b1;
      @(posedge clk); #1;
      rst          = 1'b0;
      lastReadLine = '0;
      @(negedge clk);
      checkOutput("abort read_o",    LINE_W'(bus.read_o),    '0);
      checkOutput("abort write_o",   LINE_W'(bus.write_o),   '0);
      checkOutput("abort resp_o",    LINE_W'(bus.resp_o),    '0);
      checkOutput("abort line_o",    bus.line_o,             '0);
      checkOutput("abort burst_o",   LINE_W'(bus.burst_o),   '0);
      checkOutput("abort address_o", LINE_W'(bus.address_o), '0);

      $display("[TB] fresh read after reset");
      applyStimulus(1'b1, 1'b0, 32'h0000_0047, 32'h0000_0040, '0,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'h0F0F_0F0F_F0F0_F0F0, 64'h1234_5678_9ABC_DEF0},
                    16'b0000_0000_0000_0010, 2, 1'b0);

      $display("[TB] back-to-back write, read line retained");
      applyStimulus(1'b0, 1'b0, 32'h8000_0020, 32'h8000_0020,
                    {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003,
                     64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001},
                    '0, 16'h0000, 0, 1'b0);

      for (int i = 0; i < 20 && expResp.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      if (expResp.size() != 0) reportFail("responses outstanding at end");
      checkOutput("beat queue drained", LINE_W'(expBeat.size()), '0);
      checkOutput("idle read_o",  LINE_W'(bus.read_o),  '0);
      checkOutput("idle write_o", LINE_W'(bus.write_o), '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
